// File: rtl/axis2vga_cfg_regs.sv
// -----------------------------------------------------------------------------
// axis2vga_cfg_regs
//   AXI4-Lite configuration register bank for the AXIS2VGA path.
//   Software writes land in a shadow bank; the shadow bank is copied to the
//   active bank (driven on cfg_out) only on a frame boundary, so VGA timing
//   parameters never change in the middle of a frame. Registers flagged in
//   RO_MASK are read-only and return the matching slice of status_in.
//
// Ports
//   ACLK, ARESET     clock, synchronous active-high reset
//   s_axi_aw*        write address channel (index = addr above word offset)
//   s_axi_w*         write data channel with byte strobes
//   s_axi_b*         write response (OKAY / SLVERR)
//   s_axi_ar*        read address channel
//   s_axi_r*         read data / response (OKAY / SLVERR)
//   frame_start      1-cycle frame boundary pulse from VGA timing
//   status_in        live status words, slice i belongs to register i
//   cfg_out          active configuration words, slice i belongs to register i
//   cfg_update       1-cycle pulse in the cycle cfg_out takes new values
// -----------------------------------------------------------------------------
module axis2vga_cfg_regs #(
  parameter int                  C_DATA_WIDTH = 32,
  parameter int                  C_ADDR_WIDTH = 6,
  parameter int                  NUM_REGS     = 8,
  parameter logic [NUM_REGS-1:0] RO_MASK      = '0
) (
  input  logic                             ACLK,
  input  logic                             ARESET,
  input  logic [C_ADDR_WIDTH-1:0]          s_axi_awaddr,
  input  logic                             s_axi_awvalid,
  output logic                             s_axi_awready,
  input  logic [C_DATA_WIDTH-1:0]          s_axi_wdata,
  input  logic [C_DATA_WIDTH/8-1:0]        s_axi_wstrb,
  input  logic                             s_axi_wvalid,
  output logic                             s_axi_wready,
  output logic [1:0]                       s_axi_bresp,
  output logic                             s_axi_bvalid,
  input  logic                             s_axi_bready,
  input  logic [C_ADDR_WIDTH-1:0]          s_axi_araddr,
  input  logic                             s_axi_arvalid,
  output logic                             s_axi_arready,
  output logic [C_DATA_WIDTH-1:0]          s_axi_rdata,
  output logic [1:0]                       s_axi_rresp,
  output logic                             s_axi_rvalid,
  input  logic                             s_axi_rready,
  input  logic                             frame_start,
  input  logic [NUM_REGS*C_DATA_WIDTH-1:0] status_in,
  output logic [NUM_REGS*C_DATA_WIDTH-1:0] cfg_out,
  output logic                             cfg_update
);

  localparam int STRB_W  = C_DATA_WIDTH / 8;
  localparam int IDX_LSB = $clog2(STRB_W);
  localparam int IDX_W   = C_ADDR_WIDTH - IDX_LSB;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Merge new bytes into an existing word under byte-enable control.
  function automatic logic [C_DATA_WIDTH-1:0] merge_bytes(
    input logic [C_DATA_WIDTH-1:0] old_word,
    input logic [C_DATA_WIDTH-1:0] new_word,
    input logic [STRB_W-1:0]       strb
  );
    logic [C_DATA_WIDTH-1:0] res;
    res = old_word;
    for (int k = 0; k < STRB_W; k++) begin
      if (strb[k]) res[k*8 +: 8] = new_word[k*8 +: 8];
    end
    return res;
  endfunction

  // True only for an implemented, writable register. Out-of-range indices
  // never match the loop, so they come back as not writable.
  function automatic logic is_rw_reg(input logic [IDX_W-1:0] idx);
    logic rw;
    rw = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (int'(idx) == i) rw = ~RO_MASK[i];
    end
    return rw;
  endfunction

  logic                    rdy_en;
  logic                    aw_held;
  logic [IDX_W-1:0]        aw_idx;
  logic                    w_held;
  logic [C_DATA_WIDTH-1:0] w_data;
  logic [STRB_W-1:0]       w_strb;
  logic                    dirty;

  logic [C_DATA_WIDTH-1:0] shadow [NUM_REGS];
  logic [C_DATA_WIDTH-1:0] active [NUM_REGS];

  logic [IDX_W-1:0]        ar_idx;
  logic [C_DATA_WIDTH-1:0] rd_word;
  logic                    rd_hit;

  logic aw_fire, w_fire, ar_fire;
  logic wr_land, wr_ok, commit;

  // Word-offset address bits carry no information for this bank.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{s_axi_awaddr[IDX_LSB-1:0], s_axi_araddr[IDX_LSB-1:0]};

  assign ar_idx = s_axi_araddr[C_ADDR_WIDTH-1:IDX_LSB];

  // Ready flags come only from registers; rdy_en keeps them low while in
  // reset without creating a path from ARESET to the outputs.
  assign s_axi_awready = rdy_en & ~aw_held & ~s_axi_bvalid;
  assign s_axi_wready  = rdy_en & ~w_held  & ~s_axi_bvalid;
  assign s_axi_arready = rdy_en & ~s_axi_rvalid;

  assign aw_fire = s_axi_awvalid & s_axi_awready;
  assign w_fire  = s_axi_wvalid  & s_axi_wready;
  assign ar_fire = s_axi_arvalid & s_axi_arready;

  assign wr_land = aw_held & w_held;
  assign wr_ok   = wr_land & is_rw_reg(aw_idx);
  assign commit  = frame_start & dirty;

  always_comb begin
    rd_word = '0;
    rd_hit  = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (int'(ar_idx) == i) begin
        rd_hit  = 1'b1;
        rd_word = RO_MASK[i] ? status_in[i*C_DATA_WIDTH +: C_DATA_WIDTH] : shadow[i];
      end
    end
  end

  // ---- write channel: independent AW/W holders, single outstanding write
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rdy_en       <= 1'b0;
      aw_held      <= 1'b0;
      aw_idx       <= '0;
      w_held       <= 1'b0;
      w_data       <= '0;
      w_strb       <= '0;
      s_axi_bvalid <= 1'b0;
      s_axi_bresp  <= RESP_OKAY;
    end else begin
      rdy_en <= 1'b1;
      if (aw_fire) begin
        aw_held <= 1'b1;
        aw_idx  <= s_axi_awaddr[C_ADDR_WIDTH-1:IDX_LSB];
      end
      if (w_fire) begin
        w_held <= 1'b1;
        w_data <= s_axi_wdata;
        w_strb <= s_axi_wstrb;
      end
      if (wr_land) begin
        aw_held      <= 1'b0;
        w_held       <= 1'b0;
        s_axi_bvalid <= 1'b1;
        s_axi_bresp  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (s_axi_bvalid && s_axi_bready) begin
        s_axi_bvalid <= 1'b0;
      end
    end
  end

  // ---- read channel: one-cycle registered response, held until rready
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      s_axi_rvalid <= 1'b0;
      s_axi_rdata  <= '0;
      s_axi_rresp  <= RESP_OKAY;
    end else begin
      if (ar_fire) begin
        s_axi_rvalid <= 1'b1;
        s_axi_rdata  <= rd_word;
        s_axi_rresp  <= rd_hit ? RESP_OKAY : RESP_SLVERR;
      end else if (s_axi_rvalid && s_axi_rready) begin
        s_axi_rvalid <= 1'b0;
      end
    end
  end

  // ---- commit control: a write landing with frame_start keeps dirty set
  // because its data reaches the shadow bank only after the copy.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      dirty      <= 1'b0;
      cfg_update <= 1'b0;
    end else begin
      cfg_update <= commit;
      if (wr_ok)       dirty <= 1'b1;
      else if (commit) dirty <= 1'b0;
    end
  end

  // ---- shadow / active banks. RO shadow entries are never written, so
  // their active copies stay zero.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (commit) active[i] <= shadow[i];
        if (wr_ok && (int'(aw_idx) == i)) shadow[i] <= merge_bytes(shadow[i], w_data, w_strb);
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_cfg
    assign cfg_out[g*C_DATA_WIDTH +: C_DATA_WIDTH] = active[g];
  end

endmodule
